// File: rtl/snes_console_reader.sv
// Console-side SNES controller reader: latches the pad, clocks out 16 bits and
// presents the 12 button flags active-high with a one-cycle valid strobe.
module snes_console_reader #(
  parameter int unsigned LATCH_CYCLES     = 144,
  parameter int unsigned HALF_CYCLES      = 72,
  parameter int unsigned AUTO_POLL_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        snes_data,
  output logic        snes_latch,
  output logic        snes_clk,
  output logic [11:0] buttons,
  output logic        valid,
  output logic        busy
);

  localparam int unsigned MAX_LH = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int unsigned MAX_P  = (MAX_LH > AUTO_POLL_CYCLES) ? MAX_LH : AUTO_POLL_CYCLES;
  localparam int unsigned CW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH    = 3'd1,
    SETTLE   = 3'd2,
    CLK_LOW  = 3'd3,
    CLK_HIGH = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] poll_cnt;
  logic [3:0]    k;
  logic [11:0]   shreg;
  logic          tick;
  logic          lat_last;
  logic          half_last;

  logic          latch_d;
  logic          clk_d;
  logic [11:0]   buttons_d;
  logic          valid_d;
  logic          busy_d;

  // Terminal-count decodes for the per-state dwell counter and the poll timer
  always_comb begin
    lat_last  = (cnt == CW'(LATCH_CYCLES - 1));
    half_last = (cnt == CW'(HALF_CYCLES - 1));
    tick      = (AUTO_POLL_CYCLES != 0) && (poll_cnt == CW'(AUTO_POLL_CYCLES - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start || tick) state_next = LATCH;
      LATCH:    if (lat_last)      state_next = SETTLE;
      SETTLE:   if (half_last)     state_next = CLK_LOW;
      CLK_LOW:  if (half_last)     state_next = CLK_HIGH;
      CLK_HIGH: if (half_last)     state_next = (k == 4'd15) ? DONE : CLK_LOW;
      DONE:                        state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  // Output decode from the next state so the registered pins line up with it
  always_comb begin
    latch_d   = (state_next == LATCH);
    clk_d     = (state_next != CLK_LOW);
    valid_d   = (state_next == DONE);
    busy_d    = (state_next != IDLE);
    buttons_d = (state_next == DONE) ? ~shreg : buttons;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      snes_latch <= 1'b0;
      snes_clk   <= 1'b1;
      buttons    <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      snes_latch <= latch_d;
      snes_clk   <= clk_d;
      buttons    <= buttons_d;
      valid      <= valid_d;
      busy       <= busy_d;
    end
  end

  // Dwell counter, pulse counter, bit capture and free-running poll timer
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      poll_cnt <= '0;
      k        <= '0;
      shreg    <= '0;
    end else begin
      if (AUTO_POLL_CYCLES != 0) poll_cnt <= tick ? '0 : poll_cnt + CW'(1);
      else                       poll_cnt <= '0;

      if ((state_next != state) || (state == IDLE)) cnt <= '0;
      else                                          cnt <= cnt + CW'(1);

      if ((state == SETTLE) && half_last) begin
        shreg[0] <= snes_data;
        k        <= '0;
      end
      // Sampled a full half period after the pad shifted on the rising edge
      if ((state == CLK_HIGH) && half_last) begin
        if (k < 4'd11) shreg[k + 4'd1] <= snes_data;
        k <= k + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_snes_console_reader.sv
// Bench for snes_console_reader: three instances (no auto-poll, 100, 50) against
// a timeline model plus a serial pad model that latches a press pattern.
module tb_snes_console_reader;

  localparam int L         = 4;
  localparam int H         = 2;
  localparam int T_DONE    = L + 33 * H + 1;
  localparam int FIRST_LOW = L + H + 1;
  localparam int LAST_CLK  = L + 33 * H;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_v  [3];
  logic        data_v   [3];
  logic        latch_v  [3];
  logic        sclk_v   [3];
  logic [11:0] btn_v    [3];
  logic        valid_v  [3];
  logic        busy_v   [3];

  always #5 clk = ~clk;

  snes_console_reader #(.LATCH_CYCLES(L), .HALF_CYCLES(H), .AUTO_POLL_CYCLES(0)) u0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .snes_data(data_v[0]),
    .snes_latch(latch_v[0]), .snes_clk(sclk_v[0]), .buttons(btn_v[0]),
    .valid(valid_v[0]), .busy(busy_v[0]));

  snes_console_reader #(.LATCH_CYCLES(L), .HALF_CYCLES(H), .AUTO_POLL_CYCLES(100)) u1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .snes_data(data_v[1]),
    .snes_latch(latch_v[1]), .snes_clk(sclk_v[1]), .buttons(btn_v[1]),
    .valid(valid_v[1]), .busy(busy_v[1]));

  snes_console_reader #(.LATCH_CYCLES(L), .HALF_CYCLES(H), .AUTO_POLL_CYCLES(50)) u2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .snes_data(data_v[2]),
    .snes_latch(latch_v[2]), .snes_clk(sclk_v[2]), .buttons(btn_v[2]),
    .valid(valid_v[2]), .busy(busy_v[2]));

  int          ap [3];
  int          cyc;
  int          total;
  int          bad;
  int          fail_prints;
  int          mt    [3];
  int          timer [3];
  logic [11:0] mbtn  [3];
  logic [15:0] mload [3];
  logic [15:0] pattern  [3];
  logic [15:0] pad_load [3];
  int          pad_idx  [3];
  logic        p_latch [3];
  logic        p_sclk  [3];
  logic        p_busy  [3];
  logic        need_fall [3];
  int rises [3], rise_gap [3], last_rise [3], vl_gap [3];
  int lat_hi [3], last_lat_hi [3], vhi [3], last_valid [3];
  int falls [3], first_fall_gap [3], lows [3], busy_hi [3], busy_rise [3];

  logic [15:0] tp   [3] = '{16'hFFFF, 16'h0000, 16'hF000};
  int          texp [3] = '{'hFFF, 'h000, 'h000};

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // One clock: advance the model, compare every instance, gather stats, drive pad data
  task automatic cycle();
    logic tk, e_lat, e_clk, e_busy, e_val;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        mt[i] = -1; timer[i] = 0; mbtn[i] = '0;
      end else begin
        tk = (ap[i] != 0) && (timer[i] == ap[i] - 1);
        if (ap[i] != 0) timer[i] = tk ? 0 : timer[i] + 1;
        if (mt[i] < 0) begin
          if (start_v[i] || tk) begin mt[i] = 1; mload[i] = pattern[i]; end
        end else if (mt[i] == T_DONE) mt[i] = -1;
        else mt[i]++;
        if (mt[i] == T_DONE) mbtn[i] = mload[i][11:0];
      end
      e_lat  = (mt[i] >= 1) && (mt[i] <= L);
      e_busy = (mt[i] >= 1);
      e_val  = (mt[i] == T_DONE);
      e_clk  = !((mt[i] >= FIRST_LOW) && (mt[i] <= LAST_CLK) && (((mt[i] - FIRST_LOW) % (2 * H)) < H));
      total++;
      if (latch_v[i] !== e_lat || sclk_v[i] !== e_clk || busy_v[i] !== e_busy ||
          valid_v[i] !== e_val || btn_v[i] !== mbtn[i]) begin
        bad++;
        if (fail_prints < 20) begin
          fail_prints++;
          $display("FAIL cycle_check u%0d cyc=%0d: got latch=%b clk=%b busy=%b valid=%b buttons=%h, expected latch=%b clk=%b busy=%b valid=%b buttons=%h",
                   i, cyc, latch_v[i], sclk_v[i], busy_v[i], valid_v[i], btn_v[i],
                   e_lat, e_clk, e_busy, e_val, mbtn[i]);
        end
      end

      if (latch_v[i] && !p_latch[i]) begin
        rises[i]++; rise_gap[i] = cyc - last_rise[i]; last_rise[i] = cyc;
        vl_gap[i] = cyc - last_valid[i];
      end
      if (latch_v[i]) begin lat_hi[i]++; last_lat_hi[i] = cyc; need_fall[i] = 1'b1; end
      if (valid_v[i]) begin vhi[i]++; last_valid[i] = cyc; end
      if (!sclk_v[i] && p_sclk[i]) begin
        falls[i]++;
        if (need_fall[i]) begin first_fall_gap[i] = cyc - last_lat_hi[i]; need_fall[i] = 1'b0; end
      end
      if (!sclk_v[i]) lows[i]++;
      if (busy_v[i]) busy_hi[i]++;
      if (busy_v[i] && !p_busy[i]) busy_rise[i] = cyc;

      if (latch_v[i]) begin pad_load[i] = pattern[i]; pad_idx[i] = 0; end
      else if (sclk_v[i] && !p_sclk[i] && pad_idx[i] < 16) pad_idx[i]++;
      data_v[i] = (pad_idx[i] < 16) ? ~pad_load[i][pad_idx[i][3:0]] : 1'b1;

      p_latch[i] = latch_v[i];
      p_sclk[i]  = sclk_v[i];
      p_busy[i]  = busy_v[i];
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic poll0(input logic [15:0] pat);
    pattern[0] = pat;
    start_v[0] = 1'b1;
    cycle();
    start_v[0] = 1'b0;
    run(79);
  endtask

  initial begin
    int s, r0, v0, lh0, f0, lo0, b0;
    int ra [3];
    ap[0] = 0; ap[1] = 100; ap[2] = 50;
    cyc = 0; total = 0; bad = 0; fail_prints = 0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0; data_v[i] = 1'b1; pattern[i] = '0; pad_load[i] = '0;
      mt[i] = -1; timer[i] = 0; mbtn[i] = '0; mload[i] = '0; pad_idx[i] = 16;
      p_latch[i] = 1'b0; p_sclk[i] = 1'b1; p_busy[i] = 1'b0; need_fall[i] = 1'b0;
      rises[i] = 0; rise_gap[i] = 0; last_rise[i] = 0; vl_gap[i] = 0;
      lat_hi[i] = 0; last_lat_hi[i] = 0; vhi[i] = 0; last_valid[i] = 0;
      falls[i] = 0; first_fall_gap[i] = 0; lows[i] = 0; busy_hi[i] = 0; busy_rise[i] = 0;
    end
    run(3);
    chk("reset_clk_idle", int'(sclk_v[0]), 1);
    chk("reset_busy", int'(busy_v[0]), 0);
    reset = 1'b0;
    run(5);

    // Single poll with B and R pressed: latency, waveform shape, result
    r0 = rises[0]; v0 = vhi[0]; lh0 = lat_hi[0]; f0 = falls[0]; lo0 = lows[0]; b0 = busy_hi[0];
    s = cyc;
    poll0(16'h0801);
    chk("valid_latency", last_valid[0] - s, 71);
    chk("valid_width", vhi[0] - v0, 1);
    chk("buttons_b_r", int'(btn_v[0]), 'h801);
    chk("latch_rises", rises[0] - r0, 1);
    chk("latch_width", lat_hi[0] - lh0, 4);
    chk("clk_falls", falls[0] - f0, 16);
    chk("clk_low_cycles", lows[0] - lo0, 32);
    chk("first_fall_gap", first_fall_gap[0], 3);
    chk("busy_start", busy_rise[0] - s, 1);
    chk("busy_cycles", busy_hi[0] - b0, 71);

    // Reset in the middle of a low pulse aborts the poll
    s = cyc;
    start_v[0] = 1'b1;
    cycle();
    start_v[0] = 1'b0;
    run(7);
    chk("pre_reset_clk_low", int'(sclk_v[0]), 0);
    reset = 1'b1;
    cycle();
    chk("abort_latch", int'(latch_v[0]), 0);
    chk("abort_clk", int'(sclk_v[0]), 1);
    chk("abort_buttons", int'(btn_v[0]), 'h000);
    chk("abort_valid", int'(valid_v[0]), 0);
    chk("abort_busy", int'(busy_v[0]), 0);
    run(2);
    reset = 1'b0;
    run(5);

    // All pressed, none pressed, only the discarded bits 12..15 pressed
    for (int j = 0; j < 3; j++) begin
      poll0(tp[j]);
      chk("buttons_table", int'(btn_v[0]), texp[j]);
    end

    // start pulses while busy are dropped
    r0 = rises[0]; v0 = vhi[0];
    start_v[0] = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      cycle();
      start_v[0] = (n == 10 || n == 40);
    end
    chk("busy_start_rises", rises[0] - r0, 1);
    chk("busy_start_valids", vhi[0] - v0, 1);

    // start held: back-to-back polls
    r0 = rises[0];
    start_v[0] = 1'b1;
    run(100);
    start_v[0] = 1'b0;
    run(80);
    chk("held_rises", rises[0] - r0, 2);
    chk("held_valid_to_latch", vl_gap[0], 2);

    // Auto-poll from a fresh reset, no start requests
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) ra[i] = rises[i];
    run(420);
    chk("auto0_rises", rises[0] - ra[0], 0);
    chk("auto100_rises", rises[1] - ra[1], 4);
    chk("auto100_gap", rise_gap[1], 100);
    chk("auto50_rises", rises[2] - ra[2], 4);
    chk("auto50_gap", rise_gap[2], 100);

    // Random starts, patterns and occasional resets against the model
    for (int n = 0; n < 3000; n++) begin
      cycle();
      if (reset) reset = ($urandom_range(0, 2) != 0);
      else       reset = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < 3; i++) begin
        start_v[i] = ($urandom_range(0, 15) == 0);
        if (mt[i] == 20) pattern[i] = 16'($urandom);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    run(80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
